// File: rtl/sample_hex_pkg.sv
// Shared types, ASCII constants and nibble encoder for the sample hex streamer.
// The line format is hex digits followed by LF then CR.
package sample_hex_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic [7:0] ASCII_LF        = 8'h0A;
    localparam logic [7:0] ASCII_CR        = 8'h0D;
    localparam logic [7:0] ASCII_DIGIT_OFS = 8'h30;
    localparam logic [7:0] ASCII_ALPHA_OFS = 8'h37;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib < 4'd10) ch = ASCII_DIGIT_OFS + {4'h0, nib};
        else             ch = ASCII_ALPHA_OFS + {4'h0, nib};
        return ch;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output. Head entry is visible combinationally
// on rd_data so the consumer can pop it into its own register on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push, pop;

    // Fullness/emptiness come from the registered level, so a same-cycle pop
    // never makes room for a push.
    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/sample_hex_streamer.sv
// Buffers ADC samples and streams each one as uppercase hex text terminated by
// LF, CR over a valid/ready byte interface, back-to-back when samples queue up.
module sample_hex_streamer
    import sample_hex_pkg::*;
#(
    parameter int DATA_BITS  = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [7:0]                    m_data,
    input  logic                          ovf_clear,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int NDIG  = DATA_BITS / 4;
    localparam int IDX_W = $clog2(NDIG + 2);
    localparam logic [IDX_W-1:0] LF_IDX = IDX_W'(NDIG);
    localparam logic [IDX_W-1:0] CR_IDX = IDX_W'(NDIG + 1);

    state_e                 state_q, state_d;
    logic [DATA_BITS-1:0]   line_q, line_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   m_valid_q, m_valid_d;
    logic [7:0]             m_data_q, m_data_d;
    logic                   overflow_q, overflow_d;

    logic                   fifo_full, fifo_empty, pop;
    logic [DATA_BITS-1:0]   fifo_head;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Byte at position idx of a line: digits MSB-first, then LF, then CR.
    function automatic logic [7:0] char_at(input logic [DATA_BITS-1:0] line,
                                           input logic [IDX_W-1:0]     idx);
        logic [DATA_BITS-1:0] sh;
        logic [7:0]           ch;
        sh = '0;
        if (idx < LF_IDX) begin
            sh = line >> (4 * (NDIG - 1 - int'(idx)));
            ch = nibble_to_ascii(sh[3:0]);
        end else if (idx == LF_IDX) begin
            ch = ASCII_LF;
        end else begin
            ch = ASCII_CR;
        end
        return ch;
    endfunction

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        idx_d     = idx_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    line_d    = fifo_head;
                    idx_d     = '0;
                    m_valid_d = 1'b1;
                    m_data_d  = char_at(fifo_head, '0);
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (m_ready) begin
                    if (idx_q == CR_IDX) begin
                        // Chain straight into the next queued sample without a bubble.
                        if (!fifo_empty) begin
                            pop      = 1'b1;
                            line_d   = fifo_head;
                            idx_d    = '0;
                            m_data_d = char_at(fifo_head, '0);
                        end else begin
                            m_valid_d = 1'b0;
                            state_d   = IDLE;
                        end
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        m_data_d = char_at(line_q, idx_q + 1'b1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A drop on the same edge as a clear keeps the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clear)              overflow_d = 1'b0;
        if (in_valid && fifo_full)  overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            line_q     <= '0;
            idx_q      <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            idx_q      <= idx_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_sample_hex_streamer.sv
// Directed and randomised-ready checks of the sample hex streamer byte stream,
// overflow flag, FIFO level and reset behaviour.
module tb_sample_hex_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        ovf_clear = 1'b0;
    logic        overflow;
    logic [4:0]  fifo_level;

    int   n_vec = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    bit   rdy_rand = 1'b0;
    logic [7:0] exp_q[$];
    bit   stall_pend = 1'b0;
    logic [7:0] stall_data = '0;

    sample_hex_streamer #(
        .DATA_BITS  (24),
        .FIFO_DEPTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .ovf_clear  (ovf_clear),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        logic [7:0] c;
        if (n < 4'd10) c = 8'h30 + {4'h0, n};
        else           c = 8'h41 + ({4'h0, n} - 8'd10);
        return c;
    endfunction

    task automatic push_line(input logic [23:0] s);
        for (int d = 5; d >= 0; d--) exp_q.push_back(hex_char(s[d*4 +: 4]));
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0D);
    endtask

    // Called at posedge+1; leaves at the following posedge+1 with in_valid low.
    task automatic send_sample(input logic [23:0] s);
        in_valid = 1'b1;
        in_data  = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // After send_sample: one quiet cycle, then 8 consecutive bytes, then idle.
    task automatic expect_line(input string tag, input logic [63:0] bytes);
        @(negedge clk);
        chk_vec({tag, "_latency_valid"}, m_valid, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk_vec({tag, "_valid"}, m_valid, 1'b1);
            chk_vec({tag, "_byte"}, m_data, bytes[63-8*i -: 8]);
        end
        @(negedge clk);
        chk_vec({tag, "_idle_after"}, m_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk_vec("drain_left", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        chk_vec("drain_valid", m_valid, 1'b0);
        chk_vec("drain_level", fifo_level, 5'd0);
        @(posedge clk); #1;
    endtask

    // Byte-stream monitor: inputs change at posedge+1, so the negedge values
    // are exactly what the next rising edge sees.
    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_pend) begin
                chk_vec("stall_valid", m_valid, 1'b1);
                chk_vec("stall_data", m_data, stall_data);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk_vec("extra_byte", m_valid, 1'b0);
                else                   chk_vec("stream_byte", m_data, exp_q.pop_front());
            end
            stall_pend = m_valid && !m_ready;
            stall_data = m_data;
        end else begin
            stall_pend = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rdy_rand) begin
            #1;
            m_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no finish, expected finish by 1.5ms");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] s;

        // Reset state
        #12;
        chk_vec("rst_valid", m_valid, 1'b0);
        chk_vec("rst_data", m_data, 8'h00);
        chk_vec("rst_ovf", overflow, 1'b0);
        chk_vec("rst_level", fifo_level, 5'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Single sample with ready held high
        m_ready = 1'b1;
        send_sample(24'hABC123);
        expect_line("abc123", 64'h41424331_32330A0D);

        // Two samples back-to-back: 16 handshakes with no bubble
        in_valid = 1'b1; in_data = 24'h000000;
        @(posedge clk); #1;
        in_data = 24'hFFFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk_vec("b2b_valid", m_valid, 1'b1);
            chk_vec("b2b_byte", m_data, (i < 6) ? 8'h30 : (i == 6 || i == 14) ? 8'h0A :
                                        (i == 7 || i == 15) ? 8'h0D : 8'h46);
        end
        @(negedge clk);
        chk_vec("b2b_idle_after", m_valid, 1'b0);
        @(posedge clk); #1;

        // Stalled overflow: 18 samples, 17 retained
        m_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            s = 24'h111111 * 24'(i + 1);
            if (i < 17) push_line(s);
            in_valid = 1'b1;
            in_data  = s;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk_vec("ovf_set", overflow, 1'b1);
        chk_vec("ovf_level", fifo_level, 5'd16);
        chk_vec("ovf_hold_valid", m_valid, 1'b1);
        chk_vec("ovf_hold_data", m_data, 8'h31);
        @(posedge clk); #1;
        ovf_clear = 1'b1; in_valid = 1'b1; in_data = 24'h777777;
        @(posedge clk); #1;
        ovf_clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk_vec("ovf_set_wins", overflow, 1'b1);
        chk_vec("ovf_level_still", fifo_level, 5'd16);
        @(posedge clk); #1;
        ovf_clear = 1'b1;
        @(posedge clk); #1;
        ovf_clear = 1'b0;
        @(negedge clk);
        chk_vec("ovf_cleared", overflow, 1'b0);
        @(posedge clk); #1;
        mon_en  = 1'b1;
        m_ready = 1'b1;
        wait_drain(400);

        // Random ready, 200 random samples spaced to avoid overflow
        rdy_rand = 1'b1;
        for (int i = 0; i < 200; i++) begin
            s = 24'($urandom());
            push_line(s);
            send_sample(s);
            repeat ($urandom_range(16, 40)) @(posedge clk);
            #1;
        end
        wait_drain(2000);
        rdy_rand = 1'b0;
        #2;
        m_ready = 1'b1;
        chk_vec("rand_no_ovf", overflow, 1'b0);
        mon_en = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a line
        in_valid = 1'b1; in_data = 24'h123456;
        @(posedge clk); #1;
        in_data = 24'h654321;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_vec("mid_byte3", m_data, 8'h33);
        @(posedge clk); #1;
        chk_vec("mid_level", fifo_level, 5'd1);
        rst = 1'b1;
        #2;
        chk_vec("mid_rst_valid", m_valid, 1'b0);
        chk_vec("mid_rst_level", fifo_level, 5'd0);
        chk_vec("mid_rst_data", m_data, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_sample(24'h9A0F5E);
        expect_line("fresh", 64'h39413046_35450A0D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
